dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : Shared owner-state encoding and default widths for dmem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W   = 15;
    localparam int DMEM_DATA_W   = 16;
    localparam int DMEM_MAX_WAIT = 8;
    localparam int WAIT_W        = 8;

    // Which requester owns the read data returning from the RAM next cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_AUX = 2'd2
    } owner_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Two-port (CPU / aux) arbiter onto a single-port synchronous RAM.
//          CPU has priority; define DMEM_ARB_STARVE_GUARD_EN to force an aux
//          grant after MAX_WAIT lost cycles.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..255");
    end

    owner_e              r_owner;
    owner_e              w_owner_nxt;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [DATA_W-1:0]   r_wdata_hold;
    logic                w_starve;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]   r_wait_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (!aux_req || aux_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_max_wait) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_starve = (r_wait_cnt == c_max_wait);
`else
    assign w_starve = 1'b0;
`endif

    // Grant, memory steering and owner next-state
    always_comb begin
        cpu_gnt     = 1'b0;
        aux_gnt     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = r_addr_hold;
        mem_wdata   = r_wdata_hold;
        w_owner_nxt = IDLE;
        if (Reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (cpu_req && !w_starve) begin
            cpu_gnt   = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
                w_owner_nxt = RD_CPU;
            end
        end else if (aux_req) begin
            aux_gnt   = 1'b1;
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            if (!aux_we) begin
                w_owner_nxt = RD_AUX;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_owner      <= IDLE;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_addr_hold  <= mem_addr;
            r_wdata_hold <= mem_wdata;
        end
    end

    assign cpu_rvalid = !Reset && (r_owner == RD_CPU);
    assign aux_rvalid = !Reset && (r_owner == RD_AUX);
    assign rdata      = Reset ? '0 : mem_rdata;

endmodule : dmem_arbiter
`default_nettype wire
